branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage branch/jump resolution unit, directly downstream of the branch operation decoder. It consumes the ALU result produced under that decoder's 4-bit operation and decides whether the branch is taken.
- The front end statically predicts not-taken. On a taken branch, jal or jalr, this block issues a registered PC redirect to the fetch stage and sequences the flush of wrong-path instructions in IF/ID and ID/EX.
- It also flags misaligned targets.

Parameters:
- XLEN, 32, datapath/PC width.
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (range 1..7).
- CNT_W, 16, width of optional performance counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- ex_valid_i  in  1  EX stage holds a valid instruction
- stall_i  in  1  pipeline stall; freezes EX and this block
- Opcode  in  7  EX instruction opcode
- Funct3  in  3  EX instruction funct3
- ALUResult  in  XLEN  ALU output computed under the branch operation code
- pc_ex_i  in  XLEN  PC of EX instruction
- imm_i  in  XLEN  sign-extended immediate
- rs1_i  in  XLEN  forwarded rs1 value (jalr base)
- redirect_o  out  1  one-cycle pulse: load pc_target_o into PC
- pc_target_o  out  XLEN  redirect target
- flush_o  out  1  squash IF/ID and ID/EX contents
- misalign_o  out  1  one-cycle pulse: taken target not 4-byte aligned
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Opcodes:
  - BR = 1100011
  - JAL = 1101111
  - JALR = 1100111
  - Any other opcode never redirects.
- Taken decision (combinational, from EX inputs):
  - beq (000): ALUResult == 0.
  - bne (001): ALUResult != 0.
  - blt/bge/bltu/bgeu (100/101/110/111): ALUResult[0] == 1.
  - Funct3 010/011 under BR: not taken.
  - JAL and JALR: always taken.
- Target computation, in XLEN arithmetic with wrap-around ignored:
  - BR and JAL: pc_ex_i + imm_i.
  - JALR: (rs1_i + imm_i) with bit 0 cleared.
- fire = ex_valid_i & !stall_i & taken & state==IDLE.
- FSM states:
  - IDLE:
    - If fire and target[1:0]==00: next cycle redirect_o=1, pc_target_o=target, flush_o=1; go to FLUSH with cnt=FLUSH_CYCLES-1.
    - If fire and target[1:0]!=00: next cycle misalign_o=1; no redirect, no flush; stay IDLE.
  - FLUSH:
    - flush_o=1.
    - All EX inputs are ignored; they are wrong-path instructions.
    - If cnt==0, return to IDLE; otherwise decrement cnt.
    - When FLUSH_CYCLES=1, the redirect cycle is the only flush cycle and the FSM returns to IDLE immediately.
- Latency:
  - redirect_o asserts exactly one clk after the fire cycle.
  - redirect_o is never high for two consecutive cycles.
- stall_i high:
  - Holds state, cnt, flush_o and pc_target_o.
  - A pending redirect_o pulse is delayed until the first unstalled cycle, then issued once.
- pc_target_o holds its last redirect value between redirects.
- Reset (synchronous, takes priority over everything including stall_i):
  - state=IDLE, cnt=0.
  - redirect_o=0, flush_o=0, misalign_o=0, busy_o=0, pc_target_o=0.
  - A reset asserted mid-FLUSH aborts the flush in the same edge.
- busy_o = (state != IDLE) or a redirect is pending.
- Simultaneous fire while busy is impossible by construction: the instruction is wrong-path and is ignored.

Optional Feature:
- Macro BRANCH_PERF_CNT_EN.
- When defined, adds outputs br_count_o [CNT_W] and mispredict_count_o [CNT_W], both reset to 0.
  - br_count_o increments on every accepted (non-stalled, IDLE, valid) BR instruction, taken or not.
  - mispredict_count_o increments on every redirect.
  - Both counters saturate at all-ones and do not wrap.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- beq taken: Opcode=1100011, Funct3=000, ALUResult=0, pc=0x100, imm=0x20 -> next cycle redirect_o=1, pc_target_o=0x120; flush_o high 2 cycles; busy_o high meanwhile.
- bne not taken: Funct3=001, ALUResult=0 -> redirect_o, flush_o and misalign_o stay 0; busy_o=0.
- jalr alignment: rs1=0x203, imm=0x1 -> target 0x204 (bit 0 cleared), redirect. rs1=0x202, imm=0 -> misalign_o pulse, no redirect or flush.
- Stall mid-flush: fire, then stall_i=1 for 3 cycles during FLUSH -> flush_o held high; total flush cycles excluding stalls = 2; exactly one redirect pulse.
- Wrong-path ignore and reset: a second taken blt (ALUResult=1) presented during FLUSH -> no second redirect. reset=1 during FLUSH -> all outputs 0 at the next edge.
- BRANCH_PERF_CNT_EN: 3 BR (1 taken) plus 1 jal -> br_count_o=3, mispredict_count_o=2. Preload near saturation -> counters hold at 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: taken decision, target, redirect, flush.
// Ports: clk/reset, EX inputs (valid, stall, opcode, funct3, ALU result, pc,
//   imm, rs1) -> redirect_o/pc_target_o, flush_o, misalign_o, busy_o.
// Optional BRANCH_PERF_CNT_EN adds br_count_o and mispredict_count_o.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid_i,
  input  logic            stall_i,
  input  logic [6:0]      Opcode,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] pc_ex_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
`ifdef BRANCH_PERF_CNT_EN
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispredict_count_o,
`endif
  output logic            redirect_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic            busy_o
);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      cnt;
  logic [2:0]      cnt_nxt;
  logic            pend;
  logic            pend_nxt;
  logic            misal_q;
  logic [XLEN-1:0] tgt_q;

  logic            is_br;
  logic            is_jal;
  logic            is_jalr;
  logic            br_taken;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            aligned;
  logic            fire;
  logic            fire_ok;
  logic            fire_bad;

  assign is_br   = (Opcode == OP_BR);
  assign is_jal  = (Opcode == OP_JAL);
  assign is_jalr = (Opcode == OP_JALR);

  // Condition codes are pre-evaluated by the ALU under the branch op.
  always_comb begin
    br_taken = 1'b0;
    unique case (Funct3)
      3'b000:  br_taken = (ALUResult == '0);
      3'b001:  br_taken = (ALUResult != '0);
      3'b100,
      3'b101,
      3'b110,
      3'b111:  br_taken = ALUResult[0];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = pc_ex_i + imm_i;
    unique case (1'b1)
      is_br: begin
        taken  = br_taken;
        target = pc_ex_i + imm_i;
      end
      is_jal: begin
        taken  = 1'b1;
        target = pc_ex_i + imm_i;
      end
      is_jalr: begin
        taken  = 1'b1;
        target = (rs1_i + imm_i) & ~XLEN'(1);
      end
      default: begin
        taken  = 1'b0;
        target = pc_ex_i + imm_i;
      end
    endcase
  end

  assign aligned  = (target[1:0] == 2'b00);
  // Anything seen outside IDLE is wrong-path and must be ignored.
  assign fire     = ex_valid_i & ~stall_i & taken & (state == IDLE);
  assign fire_ok  = fire & aligned;
  assign fire_bad = fire & ~aligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      misal_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend    <= pend_nxt;
      misal_q <= fire_bad;
      if (fire_ok)
        tgt_q <= target;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!stall_i) begin
      unique case (state)
        IDLE: begin
          if (fire_ok) begin
            state_nxt = FLUSH;
            cnt_nxt   = CNT_INIT;
          end
        end
        FLUSH: begin
          if (cnt == 3'd0)
            state_nxt = IDLE;
          else
            cnt_nxt = cnt - 3'd1;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // The redirect is held pending across a stall and issued exactly once.
  always_comb begin
    pend_nxt = pend;
    if (fire_ok)
      pend_nxt = 1'b1;
    else if (!stall_i)
      pend_nxt = 1'b0;
  end

  always_comb begin
    redirect_o  = pend & ~stall_i;
    flush_o     = (state == FLUSH);
    busy_o      = (state != IDLE) | pend;
    misalign_o  = misal_q;
    pc_target_o = tgt_q;
  end

`ifdef BRANCH_PERF_CNT_EN
  logic            br_acc;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  assign br_acc = ex_valid_i & ~stall_i & is_br & (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (br_acc && !(&br_cnt))
        br_cnt <= br_cnt + 1'b1;
      if (redirect_o && !(&mp_cnt))
        mp_cnt <= mp_cnt + 1'b1;
    end
  end

  assign br_count_o         = br_cnt;
  assign mispredict_count_o = mp_cnt;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit.
// Directed vectors; a negedge monitor checks redirects, misaligns, flush runs.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_i;
  logic        stall_i;
  logic [6:0]  Opcode;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult;
  logic [31:0] pc_ex_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_i;
  logic        redirect_o;
  logic [31:0] pc_target_o;
  logic        flush_o;
  logic        misalign_o;
  logic        busy_o;
`ifdef BRANCH_PERF_CNT_EN
  logic [15:0] br_count_o;
  logic [15:0] mispredict_count_o;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid_i  (ex_valid_i),
    .stall_i     (stall_i),
    .Opcode      (Opcode),
    .Funct3      (Funct3),
    .ALUResult   (ALUResult),
    .pc_ex_i     (pc_ex_i),
    .imm_i       (imm_i),
    .rs1_i       (rs1_i),
`ifdef BRANCH_PERF_CNT_EN
    .br_count_o         (br_count_o),
    .mispredict_count_o (mispredict_count_o),
`endif
    .redirect_o  (redirect_o),
    .pc_target_o (pc_target_o),
    .flush_o     (flush_o),
    .misalign_o  (misalign_o),
    .busy_o      (busy_o)
  );

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  typedef struct {
    bit          redir;
    logic [31:0] tgt;
  } ev_t;

  ev_t expq[$];
  int  flq[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor
  bit prev_red = 0;
  bit prev_fl  = 0;
  int run      = 0;

  always @(negedge clk) begin
    ev_t e;
    int  fl;
    if (redirect_o || misalign_o) begin
      if (expq.size() == 0) begin
        chk("unexpected_event", {30'd0, redirect_o, misalign_o}, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("event_kind", {31'd0, redirect_o}, {31'd0, e.redir});
        chk("event_single", {31'd0, redirect_o & misalign_o}, 32'd0);
        if (e.redir)
          chk("redirect_target", pc_target_o, e.tgt);
      end
    end
    if (prev_red && redirect_o)
      chk("redirect_back_to_back", 32'd1, 32'd0);
    if (flush_o && !stall_i)
      run++;
    if (prev_fl && !flush_o) begin
      if (flq.size() == 0) begin
        chk("unexpected_flush", run, 32'd0);
      end else begin
        fl = flq.pop_front();
        chk("flush_len", run, fl);
      end
      run = 0;
    end
    prev_red = redirect_o;
    prev_fl  = flush_o;
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1);
    ex_valid_i = 1'b1;
    Opcode     = op;
    Funct3     = f3;
    ALUResult  = alu;
    pc_ex_i    = pc;
    imm_i      = imm;
    rs1_i      = rs1;
    @(posedge clk);
    #1;
    ex_valid_i = 1'b0;
  endtask

  task automatic expect_redir(input logic [31:0] t, input int fl);
    ev_t e;
    e.redir = 1'b1;
    e.tgt   = t;
    expq.push_back(e);
    flq.push_back(fl);
  endtask

  task automatic expect_mis();
    ev_t e;
    e.redir = 1'b0;
    e.tgt   = '0;
    expq.push_back(e);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy_o && !flush_o) begin
        done = 1;
        break;
      end
    end
    if (!done)
      chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    ex_valid_i = 1'b0;
    stall_i    = 1'b0;
    Opcode     = '0;
    Funct3     = '0;
    ALUResult  = '0;
    pc_ex_i    = '0;
    imm_i      = '0;
    rs1_i      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_target", pc_target_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // beq taken
    expect_redir(32'h120, 2);
    issue(BR, 3'b000, 32'd0, 32'h100, 32'h20, 32'd0);
    @(negedge clk);
    chk("beq_busy", {31'd0, busy_o}, 32'd1);
    chk("beq_flush", {31'd0, flush_o}, 32'd1);
    wait_idle();

    // bne not taken
    issue(BR, 3'b001, 32'd0, 32'h100, 32'h20, 32'd0);
    @(negedge clk);
    chk("bne_busy", {31'd0, busy_o}, 32'd0);
    chk("bne_flush", {31'd0, flush_o}, 32'd0);
    wait_idle();

    // jalr aligned after bit-0 clear
    expect_redir(32'h204, 2);
    issue(JALR, 3'b000, 32'd0, 32'h0, 32'h1, 32'h203);
    wait_idle();

    // jalr misaligned
    expect_mis();
    issue(JALR, 3'b000, 32'd0, 32'h0, 32'h0, 32'h202);
    @(negedge clk);
    chk("mis_hold_target", pc_target_o, 32'h204);
    chk("mis_flush", {31'd0, flush_o}, 32'd0);
    wait_idle();

    // beq to misaligned target
    expect_mis();
    issue(BR, 3'b000, 32'd0, 32'h100, 32'h2, 32'd0);
    wait_idle();

    // non-branch opcode never redirects
    issue(7'b0110011, 3'b000, 32'd0, 32'h100, 32'h40, 32'd0);
    @(negedge clk);
    chk("alu_busy", {31'd0, busy_o}, 32'd0);
    wait_idle();

    // stall mid-flush
    expect_redir(32'h340, 2);
    issue(BR, 3'b000, 32'd0, 32'h300, 32'h40, 32'd0);
    @(posedge clk);
    #1;
    stall_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stall_i = 1'b0;
    wait_idle();

    // stall in redirect cycle: pulse delayed, issued once
    expect_redir(32'h410, 2);
    issue(BR, 3'b000, 32'd0, 32'h400, 32'h10, 32'd0);
    stall_i = 1'b1;
    @(negedge clk);
    chk("stall_redirect_low", {31'd0, redirect_o}, 32'd0);
    chk("stall_busy", {31'd0, busy_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    stall_i = 1'b0;
    wait_idle();

    // jal followed by wrong-path taken blt
    expect_redir(32'h600, 2);
    issue(JAL, 3'b000, 32'd0, 32'h500, 32'h100, 32'd0);
    ex_valid_i = 1'b1;
    Opcode     = BR;
    Funct3     = 3'b100;
    ALUResult  = 32'd1;
    pc_ex_i    = 32'h800;
    imm_i      = 32'h4;
    repeat (2) @(posedge clk);
    #1;
    ex_valid_i = 1'b0;
    wait_idle();

`ifdef BRANCH_PERF_CNT_EN
    chk("br_count", {16'd0, br_count_o}, 32'd5);
    chk("mp_count", {16'd0, mispredict_count_o}, 32'd5);
`endif

    // reset aborts flush
    expect_redir(32'h708, 1);
    issue(BR, 3'b000, 32'd0, 32'h700, 32'h8, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rrst_redirect", {31'd0, redirect_o}, 32'd0);
    chk("rrst_flush", {31'd0, flush_o}, 32'd0);
    chk("rrst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rrst_busy", {31'd0, busy_o}, 32'd0);
    chk("rrst_target", pc_target_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    chk("events_left", expq.size(), 32'd0);
    chk("flushes_left", flq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
